// File: rtl/halflife_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : halflife_input_cond
// Brief    : Synchronizes and debounces the half-life counter front-panel
//            controls and produces one-cycle up/down (auto-repeat) and load pulses.
// Revision : 1.0 - initial release
// ============================================================================
module halflife_input_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 256,
    parameter int REPEAT_RATE     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic       load_btn,
    input  logic [3:0] in_sw,
    output logic       up,
    output logic       down,
    output logic       load,
    output logic [3:0] in,
    output logic       conflict
);

    localparam int c_DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RW      = $clog2(c_RPT_MAX + 1);

    localparam logic [c_DW-1:0] c_DB_LIM   = c_DW'(DEBOUNCE_CYCLES);
    localparam logic [c_RW-1:0] c_DLY_LIM  = c_RW'(REPEAT_DELAY);
    localparam logic [c_RW-1:0] c_RATE_LIM = c_RW'(REPEAT_RATE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Bit map: [0]=up, [1]=down, [2]=load, [6:3]=preset switches
    logic [6:0] w_raw;
    logic [6:0] r_sync1;
    logic [6:0] r_sync2;

    assign w_raw = {in_sw, load_btn, down_btn, up_btn};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Button debounce: the next debounced level is exposed combinationally so
    // edge detection lands on the same clock edge as the level update.
    logic [2:0]      r_btn_db;
    logic [2:0]      w_btn_db_next;
    logic [c_DW-1:0] r_btn_cnt [3];

    always_comb begin
        w_btn_db_next = r_btn_db;
        for (int b = 0; b < 3; b++) begin
            if ((r_sync2[b] != r_btn_db[b]) && (r_btn_cnt[b] == c_DB_LIM)) begin
                w_btn_db_next[b] = r_sync2[b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_db <= '0;
            for (int b = 0; b < 3; b++) begin
                r_btn_cnt[b] <= '0;
            end
        end else begin
            r_btn_db <= w_btn_db_next;
            for (int b = 0; b < 3; b++) begin
                if ((r_sync2[b] == r_btn_db[b]) || (r_btn_cnt[b] == c_DB_LIM)) begin
                    r_btn_cnt[b] <= '0;
                end else begin
                    r_btn_cnt[b] <= r_btn_cnt[b] + 1'b1;
                end
            end
        end
    end

    // Preset bus debounce: any change in the synchronized word restarts the count
    logic [3:0]      w_bus_sync;
    logic [3:0]      r_bus_last;
    logic [3:0]      r_bus_db;
    logic [c_DW-1:0] r_bus_cnt;

    assign w_bus_sync = r_sync2[6:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_last <= '0;
            r_bus_db   <= '0;
            r_bus_cnt  <= '0;
        end else begin
            r_bus_last <= w_bus_sync;
            if (w_bus_sync == r_bus_db) begin
                r_bus_cnt <= '0;
            end else if (w_bus_sync != r_bus_last) begin
                r_bus_cnt <= c_DW'(1);
            end else if (r_bus_cnt == c_DB_LIM) begin
                r_bus_db  <= w_bus_sync;
                r_bus_cnt <= '0;
            end else begin
                r_bus_cnt <= r_bus_cnt + 1'b1;
            end
        end
    end

    logic w_conflict_next;
    logic r_conflict;
    logic r_load;

    assign w_conflict_next = w_btn_db_next[0] & w_btn_db_next[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict <= 1'b0;
            r_load     <= 1'b0;
        end else begin
            r_conflict <= w_conflict_next;
            r_load     <= w_btn_db_next[2] & ~r_btn_db[2];
        end
    end

    // Auto-repeat engines: channel 0 = up, channel 1 = down
    logic [1:0] w_rpt_pulse;

    for (genvar i = 0; i < 2; i++) begin : g_rpt
        state_t          r_state;
        state_t          w_state_next;
        logic [c_RW-1:0] r_rcnt;
        logic [c_RW-1:0] w_rcnt_next;
        logic            r_pulse;
        logic            w_pulse_next;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_rcnt  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_rcnt  <= w_rcnt_next;
                r_pulse <= w_pulse_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_rcnt_next  = r_rcnt;
            w_pulse_next = 1'b0;
            if (w_conflict_next || !w_btn_db_next[i]) begin
                w_state_next = ST_IDLE;
                w_rcnt_next  = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // A level still held from a conflict is not a new press
                        if (!r_btn_db[i]) begin
                            w_state_next = ST_DELAY;
                            w_rcnt_next  = '0;
                            w_pulse_next = 1'b1;
                        end
                    end
                    ST_DELAY: begin
                        if (r_rcnt + 1'b1 == c_DLY_LIM) begin
                            w_state_next = ST_REPEAT;
                            w_rcnt_next  = '0;
                            w_pulse_next = 1'b1;
                        end else begin
                            w_rcnt_next = r_rcnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_rcnt + 1'b1 == c_RATE_LIM) begin
                            w_rcnt_next  = '0;
                            w_pulse_next = 1'b1;
                        end else begin
                            w_rcnt_next = r_rcnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                        w_rcnt_next  = '0;
                    end
                endcase
            end
        end

        assign w_rpt_pulse[i] = r_pulse;
    end

    assign up       = w_rpt_pulse[0];
    assign down     = w_rpt_pulse[1];
    assign load     = r_load;
    assign in       = r_bus_db;
    assign conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_halflife_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_halflife_input_cond
// Brief    : Directed self-checking bench; expected pulses are queued at
//            stimulus time and matched against DUT pulses as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_halflife_input_cond;

    localparam int c_DB   = 4;
    localparam int c_RD   = 8;
    localparam int c_RR   = 4;
    localparam int c_LAT  = c_DB + 3;   // raw change driven after edge N -> output after edge N+LAT
    localparam int c_K_UP = 0;
    localparam int c_K_DN = 1;
    localparam int c_K_LD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_btn = 1'b0;
    logic       down_btn = 1'b0;
    logic       load_btn = 1'b0;
    logic [3:0] in_sw = 4'h0;
    logic       up;
    logic       down;
    logic       load;
    logic [3:0] in;
    logic       conflict;

    halflife_input_cond #(
        .DEBOUNCE_CYCLES (c_DB),
        .REPEAT_DELAY    (c_RD),
        .REPEAT_RATE     (c_RR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up_btn   (up_btn),
        .down_btn (down_btn),
        .load_btn (load_btn),
        .in_sw    (in_sw),
        .up       (up),
        .down     (down),
        .load     (load),
        .in       (in),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         kind;
        int         at;
        logic [3:0] val;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   mon_k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int at, input logic [3:0] val);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.val  = val;
        q.push_back(e);
    endtask

    // Press at cycle n, release at n+hold: first pulse, delayed repeat, then rate repeats
    // until the cycle before the debounced release lands.
    task automatic expect_press(input int kind, input int n, input int hold);
        int p;
        push(kind, n + c_LAT, 4'h0);
        p = n + c_LAT + c_RD;
        while (p <= n + hold + c_LAT - 1) begin
            push(kind, p, 4'h0);
            p += c_RR;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor / scoreboard consumer
    always @(negedge clk) begin
        if (up || down || load) begin
            mon_k = up ? c_K_UP : (down ? c_K_DN : c_K_LD);
            check("up_down_exclusive", {31'b0, up & down}, 32'd0);
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_pulse: observed kind=%0d at cycle %0d expected no pulse", mon_k, cyc);
            end
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                check("pulse_kind", mon_k, mon_e.kind);
                check("pulse_cycle", cyc, mon_e.at);
                if (mon_k == c_K_LD) check("load_in_value", {28'b0, in}, {28'b0, mon_e.val});
            end
        end
    end

    initial begin : stim
        int n;
        int r;

        // Reset state
        tick(2);
        check("rst_up", {31'b0, up}, 32'd0);
        check("rst_down", {31'b0, down}, 32'd0);
        check("rst_load", {31'b0, load}, 32'd0);
        check("rst_conflict", {31'b0, conflict}, 32'd0);
        check("rst_in", {28'b0, in}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Single press; release lands exactly on the first repeat edge
        n = cyc;
        up_btn = 1'b1;
        expect_press(c_K_UP, n, 8);
        wait_until(n + 8);
        up_btn = 1'b0;
        wait_until(n + 22);

        // Glitch shorter than the debounce window
        up_btn = 1'b1;
        tick(3);
        up_btn = 1'b0;
        tick(14);

        // Long hold on down with auto-repeat
        n = cyc;
        down_btn = 1'b1;
        expect_press(c_K_DN, n, 37);
        wait_until(n + 37);
        down_btn = 1'b0;
        wait_until(n + 37 + 15);

        // Preset bus with bounce, then load
        in_sw = 4'h3;
        tick(10);
        check("in_initial_3", {28'b0, in}, 32'h3);
        in_sw = 4'hA;
        tick(1);
        in_sw = 4'h3;
        tick(1);
        in_sw = 4'hB;
        tick(1);
        in_sw = 4'hA;
        n = cyc;
        wait_until(n + c_LAT - 1);
        check("in_hold_before_accept", {28'b0, in}, 32'h3);
        tick(1);
        check("in_accept_A", {28'b0, in}, 32'hA);
        n = cyc;
        load_btn = 1'b1;
        push(c_K_LD, n + c_LAT, 4'hA);
        wait_until(n + 20);
        load_btn = 1'b0;
        tick(12);

        // Conflict: up held, down added, down released, up still held
        n = cyc;
        up_btn = 1'b1;
        push(c_K_UP, n + c_LAT, 4'h0);
        push(c_K_UP, n + c_LAT + c_RD, 4'h0);
        wait_until(n + 12);
        down_btn = 1'b1;
        wait_until(n + 12 + c_LAT - 1);
        check("conflict_before", {31'b0, conflict}, 32'd0);
        tick(1);
        check("conflict_set", {31'b0, conflict}, 32'd1);
        check("conflict_up_low", {31'b0, up}, 32'd0);
        check("conflict_down_low", {31'b0, down}, 32'd0);
        wait_until(n + 30);
        down_btn = 1'b0;
        wait_until(n + 30 + c_LAT - 1);
        check("conflict_still", {31'b0, conflict}, 32'd1);
        tick(1);
        check("conflict_clear", {31'b0, conflict}, 32'd0);
        wait_until(n + 50);
        up_btn = 1'b0;
        tick(12);
        n = cyc;
        up_btn = 1'b1;
        expect_press(c_K_UP, n, 8);
        wait_until(n + 8);
        up_btn = 1'b0;
        tick(12);

        // Reset asserted while a repeat pulse is high
        n = cyc;
        up_btn = 1'b1;
        push(c_K_UP, n + c_LAT, 4'h0);
        push(c_K_UP, n + c_LAT + c_RD, 4'h0);
        push(c_K_UP, n + c_LAT + c_RD + c_RR, 4'h0);
        push(c_K_UP, n + c_LAT + c_RD + 2 * c_RR, 4'h0);
        wait_until(n + c_LAT + c_RD + 2 * c_RR);
        #2 rst = 1'b1;
        #1;
        check("rst_abort_up", {31'b0, up}, 32'd0);
        check("rst_abort_in", {28'b0, in}, 32'd0);
        tick(3);
        check("rst_hold_up", {31'b0, up}, 32'd0);
        rst = 1'b0;
        r = cyc;
        push(c_K_UP, r + c_LAT, 4'h0);
        wait_until(r + 8);
        up_btn = 1'b0;
        tick(16);

        check("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/halflife_input_cond.md
HALFLIFE_INPUT_COND -- requirements
Module: halflife_input_cond

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a level change (legal 2..65535).
REQ-002 SHALL provide parameter REPEAT_DELAY, default 256: cycles from the initial press pulse to the first auto-repeat pulse (legal 2..65535).
REQ-003 SHALL provide parameter REPEAT_RATE, default 64: cycles between later auto-repeat pulses (legal 2..65535).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port up_btn, input, 1 bit: raw asynchronous count-up button.
REQ-007 SHALL have port down_btn, input, 1 bit: raw asynchronous count-down button.
REQ-008 SHALL have port load_btn, input, 1 bit: raw asynchronous load button.
REQ-009 SHALL have port in_sw, input, 4 bits: raw asynchronous preset switches.
REQ-010 SHALL have port up, output, 1 bit: one-cycle count-up pulse to the half-life counter.
REQ-011 SHALL have port down, output, 1 bit: one-cycle count-down pulse.
REQ-012 SHALL have port load, output, 1 bit: one-cycle load pulse.
REQ-013 SHALL have port in, output, 4 bits: debounced preset value.
REQ-014 SHALL have port conflict, output, 1 bit: high while up and down are both debounced-pressed.

Function
REQ-015 SHALL pass each raw input (up_btn, down_btn, load_btn, in_sw bus) through a 2-flop synchronizer; the synchronized value is first usable 2 edges after sampling.
REQ-016 SHALL keep one debounced level per button and one 4-bit debounced bus for in_sw, each with its own stability counter.
REQ-017 SHALL increment a counter on every cycle its synchronized value differs from its debounced value, and clear it on any cycle they match; for the bus, any bit change SHALL restart the count.
REQ-018 SHALL update the debounced value on the edge where the counter would reach DEBOUNCE_CYCLES, then clear the counter; raw rise sampled at edge 0 yields debounced high after edge DEBOUNCE_CYCLES+2.
REQ-019 SHALL drive in from the debounced bus register directly, with no added latency.
REQ-020 SHALL assert load for exactly one cycle on the same edge that the load debounced level rises; load SHALL never auto-repeat, and a release SHALL produce no pulse.
REQ-021 SHALL run one repeat FSM each for up and down, with states IDLE, DELAY, REPEAT and a repeat counter sized for max(REPEAT_DELAY, REPEAT_RATE).
REQ-022 IDLE -> DELAY SHALL occur only on a debounced rising edge, emitting one pulse on that edge and clearing the repeat counter.
REQ-023 DELAY -> REPEAT SHALL occur when the counter would reach REPEAT_DELAY, emitting one pulse on that edge and clearing the counter.
REQ-024 In REPEAT, a pulse SHALL be emitted every REPEAT_RATE cycles while the button is held.
REQ-025 Falling debounced level in any state SHALL return the FSM to IDLE on that edge, clear its counter, and suppress any pulse on that edge.
REQ-026 While both up and down are debounced high, conflict SHALL be 1, both FSMs SHALL be forced to IDLE, and up and down SHALL be 0.
REQ-027 After a conflict, a still-held button SHALL NOT pulse until it is released and pressed again.
REQ-028 up and down SHALL never be high in the same cycle.
REQ-029 A pulse SHALL be high for exactly one cycle, and consecutive pulses SHALL be separated by at least 1 low cycle.

Reset
REQ-030 SHALL, while rst=1, clear all synchronizer flops, debounced levels, debounced bus, stability counters and repeat counters, and force both FSMs to IDLE.
REQ-031 SHALL, while rst=1, drive up=down=load=conflict=0 and in=4'h0.
REQ-032 After reset release with a button already held, the button SHALL be treated as a new press: one pulse after full debounce.
REQ-033 Reset asserted mid-repeat SHALL abort immediately, with no pulse on the deassertion edge.

Verification
REQ-034 With DEBOUNCE_CYCLES=4, up_btn rise sampled at edge 0 and held 10 cycles -> single up pulse high during the cycle after edge 6, then no further pulses.
REQ-035 With DEBOUNCE_CYCLES=4, up_btn glitch high for 3 cycles, then low -> no up pulse, and up debounced level stays 0.
REQ-036 With DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=4, down held 30 cycles after acceptance -> pulses at acceptance +0, +8, +12, +16, ..., and none after the release is debounced.
REQ-037 in_sw changed 4'h3 -> 4'hA with bit bounce, then stable -> in goes 4'h3 -> 4'hA only after 4 stable cycles; load press afterwards -> one load pulse with in=4'hA.
REQ-038 up held, then down also pressed -> conflict=1 with no pulses; release down -> conflict=0 and no up pulse until up is re-pressed.
REQ-039 rst=1 pulsed mid-REPEAT with up held -> outputs 0 immediately; after release, one pulse after full debounce.
